// File: rtl/qpmm_canon_red_pkg.sv
// BN254 constants and limb types shared by the QPMM canonicalisation stage.
// P, 2P, 3P and 4P are elaboration-time constants sliced into per-stage limbs.
package PARAMS_BN254_d0;

   localparam int CANON_W_IN    = 268;
   localparam int CANON_W_P     = 254;
   localparam int CANON_LIMB_W  = 67;
   localparam int CANON_TAG_W   = 8;
   localparam int CANON_N_LIMB  = 4;
   localparam int CANON_N_CHAIN = 4;

   localparam logic [CANON_W_IN-1:0] _P  =
      268'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;
   localparam logic [CANON_W_IN-1:0] _P2 = _P << 1;
   localparam logic [CANON_W_IN-1:0] _P3 = _P2 + _P;
   localparam logic [CANON_W_IN-1:0] _P4 = _P << 2;

   typedef logic [CANON_LIMB_W-1:0]          canon_limb_t;
   typedef canon_limb_t [CANON_N_CHAIN-1:0]  canon_limb4_t;
   typedef logic [CANON_W_P-1:0]             canon_res_t;

   // Element n holds limb 'limb' of (n+1)*P.
   function automatic canon_limb4_t canon_const_limbs(input int limb);
      logic [CANON_W_IN-1:0] m;
      canon_limb4_t          r;
      r = '0;
      for (int n = 0; n < CANON_N_CHAIN; n++) begin
         case (n)
            0:       m = _P;
            1:       m = _P2;
            2:       m = _P3;
            default: m = _P4;
         endcase
         r[n] = m[limb*CANON_LIMB_W +: CANON_LIMB_W];
      end
      return r;
   endfunction

endpackage

// File: rtl/qpmm_canon_red_sub_limb.sv
// One limb of the four parallel borrow chains Z-P, Z-2P, Z-3P, Z-4P.
// Purely combinational; the parent registers the difference limbs and borrows.
module canon_sub_limb
   import PARAMS_BN254_d0::*;
(
   input  canon_limb_t  z_i,
   input  canon_limb4_t c_i,
   input  logic [3:0]   b_i,
   output canon_limb4_t d_o,
   output logic [3:0]   b_o
);

   logic [3:0][CANON_LIMB_W:0] diff;

   // The extra top bit of the widened difference is the borrow out.
   always_comb begin
      diff = '0;
      d_o  = '0;
      b_o  = '0;
      for (int n = 0; n < 4; n++) begin
         diff[n] = {1'b0, z_i} - {1'b0, c_i[n]} - {{CANON_LIMB_W{1'b0}}, b_i[n]};
         d_o[n]  = diff[n][CANON_LIMB_W-1:0];
         b_o[n]  = diff[n][CANON_LIMB_W];
      end
   end

endmodule

// File: rtl/qpmm_canon_red.sv
// Reduces the redundant QPMM result Z (< 4P) to canonical Z mod P, one result per cycle.
// Stage k ripples limb k of all four chains; the output stage keeps the smallest non-negative difference.
module qpmm_canon_red
   import PARAMS_BN254_d0::*;
#(
   parameter int W_IN   = CANON_W_IN,
   parameter int W_P    = CANON_W_P,
   parameter int LIMB_W = CANON_LIMB_W,
   parameter int TAG_W  = CANON_TAG_W
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   input  logic [TAG_W-1:0] in_tag,
   input  logic [W_IN-1:0]  in_z,
   input  logic             err_clr,
   output logic             out_valid,
   output logic [TAG_W-1:0] out_tag,
   output logic [W_P-1:0]   out_r,
   output logic             err
);

   localparam int N_STG = CANON_N_LIMB;

   logic [N_STG-1:0]                  vld_q;
   logic [N_STG-1:0][TAG_W-1:0]       tag_q;
   logic [N_STG-1:0][W_IN-1:0]        z_q;
   logic [N_STG-1:0][3:0][W_IN-1:0]   dif_q;
   logic [N_STG-1:0][3:0][W_IN-1:0]   dif_d;
   logic [N_STG-1:0][3:0]             brw_q;
   logic [N_STG-1:0][3:0]             brw_in;
   logic [N_STG-1:0][3:0]             brw_d;
   canon_limb_t  [N_STG-1:0]          z_limb;
   canon_limb4_t [N_STG-1:0]          d_limb;

   logic [W_IN-1:0]  sel;
   canon_res_t       res_d;
   canon_res_t       out_r_q;
   logic [TAG_W-1:0] out_tag_q;
   logic             out_valid_q;
   logic             err_q;
   logic             err_set;

   always_comb begin
      z_limb    = '0;
      brw_in    = '0;
      z_limb[0] = in_z[LIMB_W-1:0];
      for (int k = 1; k < N_STG; k++) begin
         z_limb[k] = z_q[k-1][k*LIMB_W +: LIMB_W];
         brw_in[k] = brw_q[k-1];
      end
   end

   for (genvar k = 0; k < N_STG; k++) begin : g_stage
      localparam canon_limb4_t C_LIMBS = canon_const_limbs(k);
      canon_sub_limb u_sub (
         .z_i (z_limb[k]),
         .c_i (C_LIMBS),
         .b_i (brw_in[k]),
         .d_o (d_limb[k]),
         .b_o (brw_d[k])
      );
   end

   // Each stage inherits the finished low limbs and drops in its own limb.
   always_comb begin
      dif_d = '0;
      for (int n = 0; n < 4; n++) begin
         dif_d[0][n][LIMB_W-1:0] = d_limb[0][n];
      end
      for (int k = 1; k < N_STG; k++) begin
         for (int n = 0; n < 4; n++) begin
            dif_d[k][n]                       = dif_q[k-1][n];
            dif_d[k][n][k*LIMB_W +: LIMB_W]   = d_limb[k][n];
         end
      end
   end

   // Borrow n set means Z < (n+1)P; Z >= 4P falls through to Z-3P.
   always_comb begin
      if (!brw_q[N_STG-1][2]) begin
         sel = dif_q[N_STG-1][2];
      end else if (!brw_q[N_STG-1][1]) begin
         sel = dif_q[N_STG-1][1];
      end else if (!brw_q[N_STG-1][0]) begin
         sel = dif_q[N_STG-1][0];
      end else begin
         sel = z_q[N_STG-1];
      end
      res_d = sel[W_P-1:0];
   end

   assign err_set = vld_q[N_STG-1] & ~brw_q[N_STG-1][3];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld_q       <= '0;
         tag_q       <= '0;
         z_q         <= '0;
         dif_q       <= '0;
         brw_q       <= '0;
         out_valid_q <= 1'b0;
         out_tag_q   <= '0;
         out_r_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         vld_q[0] <= in_valid;
         if (in_valid) begin
            tag_q[0] <= in_tag;
            z_q[0]   <= in_z;
            dif_q[0] <= dif_d[0];
            brw_q[0] <= brw_d[0];
         end
         for (int k = 1; k < N_STG; k++) begin
            vld_q[k] <= vld_q[k-1];
            if (vld_q[k-1]) begin
               tag_q[k] <= tag_q[k-1];
               z_q[k]   <= z_q[k-1];
               dif_q[k] <= dif_d[k];
               brw_q[k] <= brw_d[k];
            end
         end
         out_valid_q <= vld_q[N_STG-1];
         if (vld_q[N_STG-1]) begin
            out_r_q   <= res_d;
            out_tag_q <= tag_q[N_STG-1];
         end
         if (err_set) begin
            err_q <= 1'b1;
         end else if (err_clr) begin
            err_q <= 1'b0;
         end
      end
   end

   // Z-4P only feeds the error flag; the residue never needs bits above W_P.
   logic unused_bits;
   assign unused_bits = ^{dif_q[N_STG-1][3], sel[W_IN-1:W_P]};

   assign out_valid = out_valid_q;
   assign out_tag   = out_tag_q;
   assign out_r     = out_r_q;
   assign err       = err_q;

endmodule

// File: tb/tb_qpmm_canon_red.sv
// Self-checking bench for qpmm_canon_red against a plain "subtract P until below P" model.
module tb_qpmm_canon_red;

   localparam int W_IN  = 268;
   localparam int W_P   = 254;
   localparam int TAG_W = 8;
   localparam int NCYC  = 10000;
   localparam logic [W_IN-1:0] P_BN =
      268'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             in_valid = 1'b0;
   logic [TAG_W-1:0] in_tag = '0;
   logic [W_IN-1:0]  in_z = '0;
   logic             err_clr = 1'b0;
   logic             out_valid;
   logic [TAG_W-1:0] out_tag;
   logic [W_P-1:0]   out_r;
   logic             err;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   qpmm_canon_red dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_tag    (in_tag),
      .in_z      (in_z),
      .err_clr   (err_clr),
      .out_valid (out_valid),
      .out_tag   (out_tag),
      .out_r     (out_r),
      .err       (err)
   );

   function automatic logic [W_IN-1:0] mult_p(input int m);
      logic [W_IN-1:0] acc;
      acc = '0;
      for (int i = 0; i < m; i++) acc = acc + P_BN;
      return acc;
   endfunction

   function automatic logic [W_P-1:0] ref_mod(input logic [W_IN-1:0] z);
      logic [W_IN-1:0] r;
      r = z;
      for (int i = 0; i < 8; i++) begin
         if (r >= P_BN) r = r - P_BN;
      end
      return r[W_P-1:0];
   endfunction

   function automatic logic [W_IN-1:0] rand_z();
      logic [W_IN-1:0] z;
      case ($urandom_range(0, 3))
         0, 1: begin
            z = {12'h000, $urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()};
            if (z >= mult_p(4)) z = z - mult_p(4);
         end
         2:       z = mult_p(int'($urandom_range(0, 3))) + W_IN'($urandom_range(0, 15));
         default: z = mult_p(int'($urandom_range(1, 4))) - W_IN'($urandom_range(1, 16));
      endcase
      return z;
   endfunction

   task automatic drive_idle();
      in_valid = 1'b0;
      in_z     = '0;
      in_tag   = '0;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      drive_idle();
      repeat (2) @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", out_valid); else n_pass++;
      n_checks++;
      if (out_tag !== '0) $display("FAIL reset_out_tag: got %h want 0", out_tag); else n_pass++;
      n_checks++;
      if (out_r !== '0) $display("FAIL reset_out_r: got %h want 0", out_r); else n_pass++;
      n_checks++;
      if (err !== 1'b0) $display("FAIL reset_err: got %0b want 0", err); else n_pass++;
      rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_boundary();
      logic [W_IN-1:0] zs [4];
      logic [W_P-1:0]  er [4];
      logic [W_IN-1:0] pm1;
      pm1   = P_BN - 1;
      zs[0] = '0;          er[0] = '0;
      zs[1] = P_BN;        er[1] = '0;
      zs[2] = pm1;         er[2] = pm1[W_P-1:0];
      zs[3] = mult_p(4) - 1; er[3] = pm1[W_P-1:0];
      for (int c = 0; c < 10; c++) begin
         if (c >= 5 && c < 9) begin
            n_checks++;
            if (out_valid !== 1'b1) $display("FAIL boundary_valid[%0d]: got %0b want 1", c - 5, out_valid); else n_pass++;
            n_checks++;
            if (out_r !== er[c-5]) $display("FAIL boundary_r[%0d]: got %h want %h", c - 5, out_r, er[c-5]); else n_pass++;
            n_checks++;
            if (out_tag !== TAG_W'(c - 4)) $display("FAIL boundary_tag[%0d]: got %h want %h", c - 5, out_tag, TAG_W'(c - 4)); else n_pass++;
         end else begin
            n_checks++;
            if (out_valid !== 1'b0) $display("FAIL boundary_idle[%0d]: got %0b want 0", c, out_valid); else n_pass++;
         end
         if (c < 4) begin
            in_valid = 1'b1; in_z = zs[c]; in_tag = TAG_W'(c + 1);
         end else drive_idle();
         @(negedge clk);
      end
      n_checks++;
      if (err !== 1'b0) $display("FAIL boundary_err: got %0b want 0", err); else n_pass++;
   endtask

   task automatic test_single();
      for (int c = 0; c < 7; c++) begin
         if (c == 5) begin
            n_checks++;
            if (out_valid !== 1'b1) $display("FAIL single_valid: got %0b want 1", out_valid); else n_pass++;
            n_checks++;
            if (out_r !== W_P'(5)) $display("FAIL single_r: got %h want 5", out_r); else n_pass++;
            n_checks++;
            if (out_tag !== 8'hA5) $display("FAIL single_tag: got %h want a5", out_tag); else n_pass++;
         end else if (c > 0) begin
            n_checks++;
            if (out_valid !== 1'b0) $display("FAIL single_latency[%0d]: got %0b want 0", c, out_valid); else n_pass++;
         end
         if (c == 6) begin
            n_checks++;
            if (out_r !== W_P'(5)) $display("FAIL single_hold_r: got %h want 5", out_r); else n_pass++;
         end
         if (c == 0) begin
            in_valid = 1'b1; in_z = mult_p(2) + 5; in_tag = 8'hA5;
         end else drive_idle();
         @(negedge clk);
      end
   endtask

   task automatic test_carry();
      logic [W_IN-1:0] one;
      logic [W_IN-1:0] zs [7];
      logic [W_P-1:0]  er [7];
      one   = 1;
      zs[0] = one << 201;
      zs[1] = one << 134;
      zs[2] = one << 67;
      zs[3] = P_BN + (one << 201);
      zs[4] = mult_p(3) + (one << 134);
      zs[5] = one << 253;
      zs[6] = one << 254;
      for (int i = 0; i < 7; i++) er[i] = ref_mod(zs[i]);
      for (int c = 0; c < 13; c++) begin
         if (c >= 5 && c < 12) begin
            n_checks++;
            if (out_valid !== 1'b1) $display("FAIL carry_valid[%0d]: got %0b want 1", c - 5, out_valid); else n_pass++;
            n_checks++;
            if (out_r !== er[c-5]) $display("FAIL carry_r[%0d]: got %h want %h", c - 5, out_r, er[c-5]); else n_pass++;
         end
         if (c < 7) begin
            in_valid = 1'b1; in_z = zs[c]; in_tag = TAG_W'(8'h40 + c);
         end else drive_idle();
         @(negedge clk);
      end
   endtask

   task automatic test_stream();
      bit              vhist [NCYC];
      logic [W_P-1:0]  exp_r [$];
      logic [TAG_W-1:0] exp_t [$];
      logic [W_P-1:0]  er;
      logic [TAG_W-1:0] et;
      logic            want_v;
      logic [W_IN-1:0] z;
      for (int c = 0; c < NCYC + 5; c++) begin
         want_v = (c >= 5) ? vhist[c-5] : 1'b0;
         n_checks++;
         if (out_valid !== want_v) $display("FAIL stream_valid[%0d]: got %0b want %0b", c, out_valid, want_v); else n_pass++;
         if (out_valid === 1'b1) begin
            n_checks++;
            if (exp_r.size() == 0) begin
               $display("FAIL stream_extra[%0d]: got unexpected result want none", c);
            end else begin
               n_pass++;
               er = exp_r.pop_front();
               et = exp_t.pop_front();
               n_checks++;
               if (out_r !== er) $display("FAIL stream_r[%0d]: got %h want %h", c, out_r, er); else n_pass++;
               n_checks++;
               if (out_tag !== et) $display("FAIL stream_tag[%0d]: got %h want %h", c, out_tag, et); else n_pass++;
            end
         end
         n_checks++;
         if (err !== 1'b0) $display("FAIL stream_err[%0d]: got %0b want 0", c, err); else n_pass++;
         if (c < NCYC) begin
            vhist[c] = ($urandom_range(0, 99) < 70);
            if (vhist[c]) begin
               z = rand_z();
               in_valid = 1'b1; in_z = z; in_tag = TAG_W'($urandom());
               exp_r.push_back(ref_mod(z));
               exp_t.push_back(in_tag);
            end else begin
               in_valid = 1'b0;
               in_tag   = TAG_W'($urandom());
               in_z     = {12'hFFF, $urandom(), $urandom(), $urandom(), $urandom(),
                           $urandom(), $urandom(), $urandom(), $urandom()};
            end
         end else drive_idle();
         @(negedge clk);
      end
      n_checks++;
      if (exp_r.size() != 0) $display("FAIL stream_missing: got %0d left want 0", exp_r.size()); else n_pass++;
   endtask

   task automatic test_err();
      for (int c = 0; c < 8; c++) begin
         if (c == 5) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_tag !== 8'h11) $display("FAIL err_first_out: got v=%0b tag=%h want v=1 tag=11", out_valid, out_tag); else n_pass++;
            n_checks++;
            if (err !== 1'b1) $display("FAIL err_set: got %0b want 1", err); else n_pass++;
         end else if (c == 6) begin
            n_checks++;
            if (out_r !== W_P'(3)) $display("FAIL err_second_r: got %h want 3", out_r); else n_pass++;
            n_checks++;
            if (err !== 1'b1) $display("FAIL err_sticky: got %0b want 1", err); else n_pass++;
         end else if (c == 4) begin
            n_checks++;
            if (err !== 1'b0) $display("FAIL err_early: got %0b want 0", err); else n_pass++;
         end
         if (c == 0) begin
            in_valid = 1'b1; in_z = mult_p(4); in_tag = 8'h11;
         end else if (c == 1) begin
            in_valid = 1'b1; in_z = W_IN'(3); in_tag = 8'h12;
         end else drive_idle();
         @(negedge clk);
      end
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      n_checks++;
      if (err !== 1'b0) $display("FAIL err_clear: got %0b want 0", err); else n_pass++;
      for (int c = 0; c < 7; c++) begin
         if (c == 4) begin
            n_checks++;
            if (err !== 1'b0) $display("FAIL err_before_collide: got %0b want 0", err); else n_pass++;
         end
         if (c == 5) begin
            n_checks++;
            if (err !== 1'b1) $display("FAIL err_set_wins: got %0b want 1", err); else n_pass++;
         end
         err_clr = (c == 4);
         if (c == 0) begin
            in_valid = 1'b1; in_z = mult_p(4); in_tag = 8'h13;
         end else drive_idle();
         @(negedge clk);
      end
      err_clr = 1'b0;
   endtask

   task automatic test_midreset();
      for (int c = 0; c < 3; c++) begin
         in_valid = 1'b1; in_z = rand_z(); in_tag = TAG_W'(8'h31 + c);
         @(negedge clk);
      end
      drive_idle();
      rstn = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL midrst_valid: got %0b want 0", out_valid); else n_pass++;
      n_checks++;
      if (out_r !== '0) $display("FAIL midrst_r: got %h want 0", out_r); else n_pass++;
      n_checks++;
      if (out_tag !== '0) $display("FAIL midrst_tag: got %h want 0", out_tag); else n_pass++;
      n_checks++;
      if (err !== 1'b0) $display("FAIL midrst_err: got %0b want 0", err); else n_pass++;
      @(negedge clk);
      rstn = 1'b1;
      for (int c = 0; c < 8; c++) begin
         n_checks++;
         if (out_valid !== 1'b0) $display("FAIL midrst_ghost[%0d]: got %0b want 0", c, out_valid); else n_pass++;
         @(negedge clk);
      end
      for (int c = 0; c < 6; c++) begin
         if (c == 5) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_r !== W_P'(7) || out_tag !== 8'h3C)
               $display("FAIL midrst_next: got v=%0b r=%h tag=%h want v=1 r=7 tag=3c", out_valid, out_r, out_tag);
            else n_pass++;
         end else if (c > 0) begin
            n_checks++;
            if (out_valid !== 1'b0) $display("FAIL midrst_next_early[%0d]: got %0b want 0", c, out_valid); else n_pass++;
         end
         if (c == 0) begin
            in_valid = 1'b1; in_z = P_BN + 7; in_tag = 8'h3C;
         end else drive_idle();
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_boundary();
      test_single();
      test_carry();
      test_stream();
      test_err();
      test_midreset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/qpmm_canon_red.md
# qpmm_canon_red

Final canonicalisation stage directly downstream of the BN254 QPMM Montgomery multiplier. It takes the redundant 268-bit multiplier result Z, which is guaranteed below 4P, and returns the canonical residue Z mod P in [0, P). The block is fully pipelined with one result per cycle and no backpressure, matching the upstream multiplier's issue rate. A valid/tag sideband travels with each operand, and a sticky error flag records any out-of-contract input (Z ≥ 4P).

## Interface
Parameters:
- W_IN, 268, width of incoming redundant value Z
- W_P, 254, width of canonical residue
- LIMB_W, 67, limb width of the borrow chain (4 limbs × 67 = 268)
- TAG_W, 8, width of the opaque tag carried alongside each operand

Ports:
- clk  in  1  clock
- rstn  in  1  reset; one clock, reset asynchronous, active-low
- in_valid  in  1  in_z/in_tag are valid this cycle
- in_tag  in  TAG_W  opaque tag
- in_z  in  W_IN  QPMM output Z
- err_clr  in  1  clears err
- out_valid  out  1  out_r/out_tag valid
- out_tag  out  TAG_W  tag of the result
- out_r  out  W_P  Z mod P
- err  out  1  sticky: some accepted Z was ≥ 4P

## Operation
- Four parallel borrow chains compute Z−P, Z−2P, Z−3P and Z−4P, limb-serially over 4 limbs of LIMB_W bits (limb 0 = LSB).
- Stage k (k = 0..3) handles limb k of all four chains and registers one borrow per chain.
  - Not-yet-processed limbs of Z are skewed forward; processed difference limbs are delayed so all limbs align at stage 4.
- Final borrow bN = 1 means Z < N·P.
- Stage 4 selection:
  - !b3 → Z−3P
  - else !b2 → Z−2P
  - else !b1 → Z−P
  - else → Z
  - Result truncated to W_P bits, since it is < P by construction.
- Z ≥ 4P (!b4):
  - Output Z−3P truncated; value undefined by contract.
  - err set on the same cycle out_valid rises for that operand.
- err is sticky until err_clr. If set and clear fire in the same cycle, set wins.
- Data/tag pipeline registers load only when the stage's valid is high. When out_valid is low, out_r/out_tag hold their last value.
- Constants P, 2P, 3P, 4P are compile-time; there are no multipliers.

## Timing
- Latency: 5 cycles. An operand with in_valid high at edge t gives out_valid high at edge t+5.
- Throughput: 1 per cycle, back-to-back, no stalls. Gaps in in_valid propagate as bubbles in out_valid.
- No ready signal exists. The consumer must accept every out_valid cycle.
- Reset values: out_valid 0, out_tag 0, out_r 0, err 0, all internal valid bits 0.
- Reset asserted mid-stream discards every in-flight operand. The first out_valid after rstn deasserts belongs to an operand presented after release.
- in_z is ignored whenever in_valid is low; no X-propagation to outputs is allowed.

## Structure
- The shared BN254 parameter package (PARAMS_BN254_d0) gains:
  - constants _P, _P2, _P3, _P4 (W_IN bits)
  - typedef canon_limb_t (LIMB_W bits)
  - typedef canon_res_t (W_P bits)
- One sub-module, canon_sub_limb:
  - inputs: one LIMB_W limb of Z, four constant limbs, four borrow-ins
  - outputs: four difference limbs, four borrow-outs
  - purely combinational
  - instantiated once per stage 0..3; registers live in the parent.

## Test plan
- Boundary values, tags 0x01..0x04 on consecutive cycles:
  - Z=0 → out_r=0, tag 0x01
  - Z=P → 0, tag 0x02
  - Z=P−1 → P−1, tag 0x03
  - Z=4P−1 → P−1, tag 0x04
  - Results arrive on 4 consecutive cycles starting at t+5; err stays 0.
- Z=2P+5 with tag 0xA5 → out_r=5, out_tag 0xA5, exactly 5 cycles later.
- Z=4P then Z=3 → err rises with the first result and stays high; second result is 3. Pulse err_clr → err=0. Assert err_clr on the same cycle a new Z=4P result emerges → err=1.
- Streaming test:
  - 10 000 random Z < 4P, in_valid toggled randomly (~70 % duty).
  - Compare against a model of Z mod P.
  - out_valid pattern must equal in_valid delayed by 5 cycles.
- Carry propagation: Z = P with every limb boundary carrying (Z = P + 2^67 − 2^67 patterns, i.e. limbs crafted so a borrow ripples through all 4 limbs) → correct residue.
- Reset mid-stream:
  - Pulse rstn low for 1 cycle with 3 operands in flight → out_valid=0, out_r=0, out_tag=0 immediately, and none of the 3 ever appear.
  - Next operand emerges 5 cycles after its issue.
